mem_loader_ctrl: RTL and testbench

Byte-stream boot loader and CPU run controller for the five-stage pipelined RISC-V core. It accepts framed commands from a serial receiver (valid/ready byte interface) and writes byte data into instruction memory or data memory through their byte write ports. It holds the CPU in reset while loading and releases it on command. On FPGA it replaces the simulation-only preload of instruction and data memory.

---
 rtl/mem_loader_ctrl_pkg.sv | 29 ++
 rtl/ldr_timeout_cnt.sv | 27 ++
 rtl/mem_loader_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_loader_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_ctrl_pkg.sv
// Shared types and codes for the byte-stream boot loader.
// Command bytes, sticky error codes and FSM state encodings.
package mem_loader_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AH   = 3'd1,
        ST_AL   = 3'd2,
        ST_LH   = 3'd3,
        ST_LL   = 3'd4,
        ST_DATA = 3'd5
    } ldr_state_e;

    localparam logic [7:0] LDR_CMD_IMW  = 8'h01;
    localparam logic [7:0] LDR_CMD_DMW  = 8'h02;
    localparam logic [7:0] LDR_CMD_RUN  = 8'h03;
    localparam logic [7:0] LDR_CMD_HALT = 8'h04;
    localparam logic [7:0] LDR_CMD_CLR  = 8'h05;

    localparam logic [2:0] LDR_ERR_NONE    = 3'd0;
    localparam logic [2:0] LDR_ERR_BADCMD  = 3'd1;
    localparam logic [2:0] LDR_ERR_RANGE   = 3'd2;
    localparam logic [2:0] LDR_ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] LDR_ERR_RUNWR   = 3'd4;

    localparam int unsigned LDR_IM_SIZE_DEF = 4096;
    localparam int unsigned LDR_DM_SIZE_DEF = 4096;

endpackage

// File: rtl/ldr_timeout_cnt.sv
// Inter-byte timeout counter; o_expired is high for the single cycle
// after TIMEOUT_CYC enabled, uncleared cycles have elapsed.
module ldr_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst || i_clr || o_expired) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_loader_ctrl.sv
// Boot loader: parses framed byte commands, writes IM/DM byte ports
// and controls the CPU reset line.
module mem_loader_ctrl
    import mem_loader_ctrl_pkg::*;
#(
    parameter int unsigned IM_SIZE     = LDR_IM_SIZE_DEF,
    parameter int unsigned DM_SIZE     = LDR_DM_SIZE_DEF,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [7:0]        dm_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic [2:0]        err_code
);

    ldr_state_e        r_state;
    logic              r_dm;
    logic              r_blk;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_len;
    logic              r_rdy;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [7:0]        r_im_wdata;
    logic              r_dm_we;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [7:0]        r_dm_wdata;
    logic              r_cpu;
    logic [2:0]        r_err;

    logic              w_acc;
    logic              w_busy;
    logic              w_exp;
    logic              w_in_rng;
    logic [15:0]       w_word;
    ldr_state_e        w_st;
    logic [2:0]        w_err_set;
    logic              w_clr;

    assign in_ready  = r_rdy;
    assign im_we     = r_im_we;
    assign im_addr   = r_im_addr;
    assign im_wdata  = r_im_wdata;
    assign dm_we     = r_dm_we;
    assign dm_addr   = r_dm_addr;
    assign dm_wdata  = r_dm_wdata;
    assign cpu_rst_n = r_cpu;
    assign busy      = w_busy;
    assign err_code  = r_err;

    assign w_acc    = in_valid && r_rdy;
    assign w_busy   = (r_state != ST_IDLE);
    assign w_word   = {r_hi, in_data};
    // An expiring frame hands the byte on the same edge to IDLE as a command
    assign w_st     = w_exp ? ST_IDLE : r_state;
    assign w_in_rng = 32'(r_addr) < (r_dm ? 32'(DM_SIZE) : 32'(IM_SIZE));

    ldr_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_acc || !w_busy),
        .i_en      (w_busy),
        .o_expired (w_exp)
    );

    always_comb begin
        w_err_set = LDR_ERR_NONE;
        w_clr     = 1'b0;
        if (w_acc && w_st == ST_IDLE) begin
            case (in_data)
                LDR_CMD_IMW, LDR_CMD_DMW: begin
                    if (r_cpu) w_err_set = LDR_ERR_RUNWR;
                end
                LDR_CMD_RUN, LDR_CMD_HALT: ;
                LDR_CMD_CLR: w_clr = 1'b1;
                default: w_err_set = LDR_ERR_BADCMD;
            endcase
        end
        if (w_acc && w_st == ST_DATA && !r_blk && !w_in_rng) begin
            w_err_set = LDR_ERR_RANGE;
        end
        if (w_exp) w_err_set = LDR_ERR_TIMEOUT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dm       <= 1'b0;
            r_blk      <= 1'b0;
            r_hi       <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_rdy      <= 1'b0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
            r_cpu      <= 1'b0;
            r_err      <= LDR_ERR_NONE;
        end else begin
            r_rdy   <= 1'b1;
            r_im_we <= 1'b0;
            r_dm_we <= 1'b0;
            if (w_clr) begin
                r_err <= LDR_ERR_NONE;
            end else if (r_err == LDR_ERR_NONE) begin
                r_err <= w_err_set;
            end
            if (w_exp) r_state <= ST_IDLE;
            if (w_acc) begin
                case (w_st)
                    ST_IDLE: begin
                        case (in_data)
                            LDR_CMD_IMW, LDR_CMD_DMW: begin
                                r_state <= ST_AH;
                                r_dm    <= (in_data == LDR_CMD_DMW);
                                r_blk   <= r_cpu;
                            end
                            LDR_CMD_RUN:  r_cpu <= 1'b1;
                            LDR_CMD_HALT: r_cpu <= 1'b0;
                            default: ;
                        endcase
                    end
                    ST_AH: begin
                        r_hi    <= in_data;
                        r_state <= ST_AL;
                    end
                    ST_AL: begin
                        r_addr  <= ADDR_W'(w_word);
                        r_state <= ST_LH;
                    end
                    ST_LH: begin
                        r_hi    <= in_data;
                        r_state <= ST_LL;
                    end
                    ST_LL: begin
                        r_len   <= w_word;
                        r_state <= (w_word == 16'd0) ? ST_IDLE : ST_DATA;
                    end
                    ST_DATA: begin
                        if (!r_blk && w_in_rng) begin
                            if (r_dm) begin
                                r_dm_we    <= 1'b1;
                                r_dm_addr  <= r_addr;
                                r_dm_wdata <= in_data;
                            end else begin
                                r_im_we    <= 1'b1;
                                r_im_addr  <= r_addr;
                                r_im_wdata <= in_data;
                            end
                        end
                        r_addr <= r_addr + ADDR_W'(1);
                        r_len  <= r_len - 16'd1;
                        if (r_len == 16'd1) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_loader_ctrl.sv
// Directed bench for mem_loader_ctrl with a frame-level reference model
// compared against the DUT on every falling edge.
module tb_mem_loader_ctrl;

    localparam int IM = 1024;
    localparam int DM = 512;
    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [7:0]  im_wdata;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [7:0]  dm_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic [2:0]  err_code;

    mem_loader_ctrl #(
        .IM_SIZE     (IM),
        .DM_SIZE     (DM),
        .ADDR_W      (16),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .err_code  (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model state: bytes of the frame in progress, CPU run flag, error
    logic [7:0]  m_frame[$];
    bit          m_blk;
    bit          m_cpu;
    logic [2:0]  m_err;
    int          m_gap;
    bit          m_on;
    bit          p_we;
    bit          p_dm;
    logic [15:0] p_a;
    logic [7:0]  p_d;

    logic [7:0]  im_mem[IM];
    logic [7:0]  dm_mem[DM];
    int          im_cnt;
    int          dm_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_err(input logic [2:0] c);
        if (m_err == 3'd0) m_err = c;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        int len;
        int lim;
        logic [15:0] a;
        if (m_frame.size() > 0 && m_gap == TO) begin
            set_err(3'd3);
            m_frame.delete();
        end
        m_gap = 0;
        if (m_frame.size() == 0) begin
            case (b)
                8'h01, 8'h02: begin
                    m_frame.push_back(b);
                    m_blk = m_cpu;
                    if (m_cpu) set_err(3'd4);
                end
                8'h03: m_cpu = 1'b1;
                8'h04: m_cpu = 1'b0;
                8'h05: m_err = 3'd0;
                default: set_err(3'd1);
            endcase
        end else begin
            m_frame.push_back(b);
            n = m_frame.size();
            if (n >= 5) begin
                len = int'({m_frame[3], m_frame[4]});
                if (n == 5 && len == 0) begin
                    m_frame.delete();
                end else if (n > 5) begin
                    a = {m_frame[1], m_frame[2]} + 16'(n - 6);
                    lim = (m_frame[0] == 8'h02) ? DM : IM;
                    if (!m_blk) begin
                        if (int'(a) < lim) begin
                            p_we = 1'b1;
                            p_dm = (m_frame[0] == 8'h02);
                            p_a  = a;
                            p_d  = b;
                        end else begin
                            set_err(3'd2);
                        end
                    end
                    if (n - 5 == len) m_frame.delete();
                end
            end
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_hex(input string s);
        for (int i = 0; i + 1 < s.len(); i += 3) begin
            send(8'(s.substr(i, i + 1).atohex()));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            m_gap++;
            if (m_frame.size() > 0 && m_gap == TO + 1) begin
                set_err(3'd3);
                m_frame.delete();
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_on = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_im_we", 32'(im_we), 32'd0);
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_addr", {im_addr, dm_addr}, 32'd0);
        chk("rst_wdata", {16'd0, im_wdata, dm_wdata}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cpu", 32'(cpu_rst_n), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        rst = 1'b0;
        m_frame.delete();
        m_cpu = 1'b0;
        m_err = 3'd0;
        m_gap = 0;
        p_we  = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);
        m_on = 1'b1;
    endtask

    always @(negedge clk) begin
        if (m_on) begin
            chk("im_we", 32'(im_we), 32'(p_we && !p_dm));
            chk("dm_we", 32'(dm_we), 32'(p_we && p_dm));
            if (p_we && !p_dm) begin
                chk("im_addr", 32'(im_addr), 32'(p_a));
                chk("im_wdata", 32'(im_wdata), 32'(p_d));
            end
            if (p_we && p_dm) begin
                chk("dm_addr", 32'(dm_addr), 32'(p_a));
                chk("dm_wdata", 32'(dm_wdata), 32'(p_d));
            end
            chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
            chk("err_code", 32'(err_code), 32'(m_err));
            chk("busy", 32'(busy), 32'(m_frame.size() > 0));
            chk("in_ready", 32'(in_ready), 32'd1);
            if (im_we === 1'b1) begin
                im_mem[im_addr[9:0]] = im_wdata;
                im_cnt++;
            end
            if (dm_we === 1'b1) begin
                dm_mem[dm_addr[8:0]] = dm_wdata;
                dm_cnt++;
            end
            p_we = 1'b0;
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        m_on     = 1'b0;
        m_cpu    = 1'b0;
        m_blk    = 1'b0;
        m_err    = 3'd0;
        m_gap    = 0;
        p_we     = 1'b0;
        p_dm     = 1'b0;
        p_a      = '0;
        p_d      = '0;
        im_cnt   = 0;
        dm_cnt   = 0;
        for (int i = 0; i < IM; i++) im_mem[i] = 8'h00;
        for (int i = 0; i < DM; i++) dm_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        send_hex("01 00 10 00 04 AA BB CC DD");
        idle(2);
        chk("im10", 32'(im_mem[16]), 32'hAA);
        chk("im13", 32'(im_mem[19]), 32'hDD);
        chk("im_cnt1", 32'(im_cnt), 32'd4);
        chk("dm_cnt1", 32'(dm_cnt), 32'd0);

        send_hex("02 00 00 00 02 11 22 03");
        idle(1);
        chk("dm0", 32'(dm_mem[0]), 32'h11);
        chk("dm1", 32'(dm_mem[1]), 32'h22);
        chk("run_cpu", 32'(cpu_rst_n), 32'd1);

        send_hex("04 01 03 FF 00 02 5A A5");
        idle(1);
        chk("im3ff", 32'(im_mem[1023]), 32'h5A);
        chk("im_cnt2", 32'(im_cnt), 32'd5);
        chk("range_err", 32'(err_code), 32'd2);

        send_hex("05 03 02 00 00 00 01 77");
        idle(1);
        chk("runwr_err", 32'(err_code), 32'd4);
        chk("dm_cnt2", 32'(dm_cnt), 32'd2);
        send_hex("05");
        chk("clr_err", 32'(err_code), 32'd0);
        send_hex("04");
        chk("halt_cpu", 32'(cpu_rst_n), 32'd0);

        send_hex("01 00 00");
        idle(TO);
        chk("tmo_busy_hold", 32'(busy), 32'd1);
        idle(1);
        chk("tmo_busy_fall", 32'(busy), 32'd0);
        chk("tmo_err", 32'(err_code), 32'd3);
        send_hex("03");
        chk("tmo_run", 32'(cpu_rst_n), 32'd1);
        send_hex("05 04");

        send_hex("01 00 00");
        idle(TO);
        send_hex("03");
        chk("tmo_edge_run", 32'(cpu_rst_n), 32'd1);
        chk("tmo_edge_err", 32'(err_code), 32'd3);
        send_hex("05 04");

        send_hex("7F");
        chk("bad_cmd", 32'(err_code), 32'd1);
        send_hex("01 00 00 00 00");
        chk("len0_busy", 32'(busy), 32'd0);
        chk("first_wins", 32'(err_code), 32'd1);
        send_hex("05");

        send_hex("01 FF FF 00 02 E1 E2");
        idle(1);
        chk("wrap_im0", 32'(im_mem[0]), 32'hE2);
        chk("wrap_err", 32'(err_code), 32'd2);
        send_hex("05");

        send_hex("03");
        do_reset();
        chk("rst_cpu_low", 32'(cpu_rst_n), 32'd0);

        send_hex("01 00 20 00 02 AA");
        in_data  = 8'hBB;
        in_valid = 1'b1;
        do_reset();
        idle(2);
        chk("mid_rst_20", 32'(im_mem[32]), 32'hAA);
        chk("mid_rst_21", 32'(im_mem[33]), 32'h00);
        send_hex("02 00 05 00 01 3C");
        idle(1);
        chk("post_rst_dm", 32'(dm_mem[5]), 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
